// File: rtl/bwt_pkg.sv
// Shared widths, source encodings and the request payload for the BWT
// occurrence-table request path.
package bwt_pkg;

    localparam int unsigned ADDR_W = 42;
    localparam int unsigned RN_W   = 6;

    localparam logic SRC_FWD = 1'b0;
    localparam logic SRC_BCK = 1'b1;

    typedef struct packed {
        logic [ADDR_W-1:0] addr_k;
        logic [ADDR_W-1:0] addr_l;
        logic [RN_W-1:0]   read_num;
    } req_t;

endpackage

// File: rtl/req_fifo.sv
// Small synchronous request FIFO; one wrap bit on each pointer tells full from empty.
module req_fifo
    import bwt_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  req_t                       push_data,
    input  logic                       pop,
    output req_t                       head,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    req_t          mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          do_push;
    logic          do_pop;

    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    assign count = wr_ptr - rd_ptr;
    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/bwt_req_arbiter.sv
// Round-robin share of the occurrence-table request port between the forward
// and backward pipelines, with credit throttling and sticky error flags.
module bwt_req_arbiter
    import bwt_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned MAX_OUTST  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              f_req_valid,
    input  logic [ADDR_W-1:0] f_addr_k,
    input  logic [ADDR_W-1:0] f_addr_l,
    input  logic [RN_W-1:0]   f_read_num,
    output logic              f_stall,
    input  logic              b_req_valid,
    input  logic [ADDR_W-1:0] b_addr_k,
    input  logic [ADDR_W-1:0] b_addr_l,
    input  logic [RN_W-1:0]   b_read_num,
    output logic              b_stall,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_addr_k,
    output logic [ADDR_W-1:0] mem_addr_l,
    output logic              mem_req_src,
    output logic [RN_W-1:0]   mem_read_num,
    input  logic              mem_rsp_valid,
    output logic [5:0]        outstanding,
    output logic              err_overflow,
    output logic              err_underflow,
    output logic              idle
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned OW = 6;

    req_t          f_in, b_in, f_head, b_head, g_head;
    logic [CW-1:0] f_count, b_count;
    logic          f_full, f_empty, b_full, b_empty;
    logic          f_pop, b_pop;
    logic          grant_src, handshake, credit_ok;
    logic          rr_q, lock_q, lock_src_q;
    logic [OW-1:0] outst_q, outst_d;
    logic          err_ovf_q, err_unf_q, underflow_c;

    assign f_in = '{addr_k: f_addr_k, addr_l: f_addr_l, read_num: f_read_num};
    assign b_in = '{addr_k: b_addr_k, addr_l: b_addr_l, read_num: b_read_num};

    req_fifo #(.DEPTH(FIFO_DEPTH)) u_fwd_fifo (
        .clk(clk), .rst(rst), .push(f_req_valid), .push_data(f_in), .pop(f_pop),
        .head(f_head), .count(f_count), .full(f_full), .empty(f_empty)
    );

    req_fifo #(.DEPTH(FIFO_DEPTH)) u_bck_fifo (
        .clk(clk), .rst(rst), .push(b_req_valid), .push_data(b_in), .pop(b_pop),
        .head(b_head), .count(b_count), .full(b_full), .empty(b_empty)
    );

    // One slot stays free for the request already in flight when the stall lands.
    assign f_stall = (f_count >= CW'(FIFO_DEPTH - 1));
    assign b_stall = (b_count >= CW'(FIFO_DEPTH - 1));

    assign credit_ok     = (outst_q < OW'(MAX_OUTST));
    assign mem_req_valid = (~f_empty | ~b_empty) & credit_ok;
    assign handshake     = mem_req_valid & mem_req_ready;

    // A stalled offer keeps its source; otherwise round-robin among non-empty sources.
    always_comb begin
        grant_src = SRC_FWD;
        if (lock_q)                grant_src = lock_src_q;
        else if (!f_empty && !b_empty) grant_src = rr_q;
        else if (!b_empty)         grant_src = SRC_BCK;
    end

    assign g_head = (grant_src == SRC_BCK) ? b_head : f_head;
    assign f_pop  = handshake & (grant_src == SRC_FWD);
    assign b_pop  = handshake & (grant_src == SRC_BCK);

    assign mem_addr_k   = mem_req_valid ? g_head.addr_k   : '0;
    assign mem_addr_l   = mem_req_valid ? g_head.addr_l   : '0;
    assign mem_read_num = mem_req_valid ? g_head.read_num : '0;
    assign mem_req_src  = mem_req_valid & grant_src;

    always_comb begin
        outst_d     = outst_q;
        underflow_c = 1'b0;
        unique case ({handshake, mem_rsp_valid})
            2'b10:   outst_d = outst_q + OW'(1);
            2'b01: begin
                if (outst_q == '0) underflow_c = 1'b1;
                else               outst_d = outst_q - OW'(1);
            end
            default: outst_d = outst_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_q       <= SRC_FWD;
            lock_q     <= 1'b0;
            lock_src_q <= SRC_FWD;
            outst_q    <= '0;
            err_ovf_q  <= 1'b0;
            err_unf_q  <= 1'b0;
        end else begin
            if (handshake) rr_q <= ~grant_src;
            lock_q     <= mem_req_valid & ~mem_req_ready;
            lock_src_q <= grant_src;
            outst_q    <= outst_d;
            err_ovf_q  <= err_ovf_q | (f_req_valid & f_full & ~f_pop)
                                    | (b_req_valid & b_full & ~b_pop);
            err_unf_q  <= err_unf_q | underflow_c;
        end
    end

    assign outstanding   = outst_q;
    assign err_overflow  = err_ovf_q;
    assign err_underflow = err_unf_q;
    assign idle          = f_empty & b_empty & (outst_q == '0);

endmodule

// File: tb/tb_bwt_req_arbiter.sv
// Scoreboard bench for bwt_req_arbiter: per-source expected queues checked on every handshake.
module tb_bwt_req_arbiter;
    import bwt_pkg::*;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              f_req_valid = 1'b0, b_req_valid = 1'b0;
    logic [ADDR_W-1:0] f_addr_k = '0, f_addr_l = '0, b_addr_k = '0, b_addr_l = '0;
    logic [RN_W-1:0]   f_read_num = '0, b_read_num = '0;
    logic              f_stall, b_stall, mem_req_valid, mem_req_src;
    logic              mem_req_ready = 1'b0, mem_rsp_valid = 1'b0;
    logic [ADDR_W-1:0] mem_addr_k, mem_addr_l;
    logic [RN_W-1:0]   mem_read_num;
    logic [5:0]        outstanding;
    logic              err_overflow, err_underflow, idle;

    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    req_t fq[$];
    req_t bq[$];
    logic log_src[$];
    logic [RN_W-1:0] log_rn[$];
    int   log_cyc[$];

    bwt_req_arbiter dut (
        .clk(clk), .rst(rst),
        .f_req_valid(f_req_valid), .f_addr_k(f_addr_k), .f_addr_l(f_addr_l),
        .f_read_num(f_read_num), .f_stall(f_stall),
        .b_req_valid(b_req_valid), .b_addr_k(b_addr_k), .b_addr_l(b_addr_l),
        .b_read_num(b_read_num), .b_stall(b_stall),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_addr_k(mem_addr_k), .mem_addr_l(mem_addr_l), .mem_req_src(mem_req_src),
        .mem_read_num(mem_read_num), .mem_rsp_valid(mem_rsp_valid),
        .outstanding(outstanding), .err_overflow(err_overflow),
        .err_underflow(err_underflow), .idle(idle)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Handshake monitor: inputs are stable at the falling edge, so valid&ready here is a transfer.
    always @(negedge clk) begin : monitor
        req_t got, exp;
        if (rst && mem_req_valid && mem_req_ready) begin
            got.addr_k = mem_addr_k;
            got.addr_l = mem_addr_l;
            got.read_num = mem_read_num;
            log_src.push_back(mem_req_src);
            log_rn.push_back(mem_read_num);
            log_cyc.push_back(cyc);
            tests++;
            if ((mem_req_src ? bq.size() : fq.size()) == 0) begin
                fails++;
                $display("FAIL unexpected_issue src=%0d rn=%0d with empty expected queue", mem_req_src, mem_read_num);
            end else begin
                exp = mem_req_src ? bq.pop_front() : fq.pop_front();
                if (got !== exp) begin
                    fails++;
                    $display("FAIL issue_data src=%0d got k=%h l=%h rn=%0d exp k=%h l=%h rn=%0d",
                             mem_req_src, got.addr_k, got.addr_l, got.read_num,
                             exp.addr_k, exp.addr_l, exp.read_num);
                end
            end
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_f(input logic [ADDR_W-1:0] k, input logic [ADDR_W-1:0] l,
                           input logic [RN_W-1:0] rn, input bit accepted);
        f_req_valid = 1'b1; f_addr_k = k; f_addr_l = l; f_read_num = rn;
        if (accepted) fq.push_back('{addr_k: k, addr_l: l, read_num: rn});
    endtask

    task automatic drive_b(input logic [ADDR_W-1:0] k, input logic [ADDR_W-1:0] l,
                           input logic [RN_W-1:0] rn, input bit accepted);
        b_req_valid = 1'b1; b_addr_k = k; b_addr_l = l; b_read_num = rn;
        if (accepted) bq.push_back('{addr_k: k, addr_l: l, read_num: rn});
    endtask

    task automatic reset_dut();
        rst = 1'b0;
        f_req_valid = 1'b0; b_req_valid = 1'b0;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
        fq.delete(); bq.delete(); log_src.delete(); log_rn.delete(); log_cyc.delete();
        cycle();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        logic [136:0] outs;
        cycle();
        outs = {f_stall, b_stall, mem_req_valid, mem_addr_k, mem_addr_l, mem_req_src,
                mem_read_num, outstanding, err_overflow, err_underflow};
        tests++;
        if (outs !== '0 || idle !== 1'b1) begin
            fails++; $display("FAIL reset_initial outs=%h idle=%b exp 0/1", outs, idle);
        end
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_f(42'(i + 1), 42'(i + 2), 6'(i), 1'b1);
            cycle();
        end
        f_req_valid = 1'b0;
        tests++;
        if (f_stall !== 1'b1 || mem_req_valid !== 1'b1 || idle !== 1'b0) begin
            fails++; $display("FAIL reset_pre_traffic stall=%b valid=%b idle=%b exp 1/1/0", f_stall, mem_req_valid, idle);
        end
        rst = 1'b0;
        #1;
        outs = {f_stall, b_stall, mem_req_valid, mem_addr_k, mem_addr_l, mem_req_src,
                mem_read_num, outstanding, err_overflow, err_underflow};
        tests++;
        if (outs !== '0 || idle !== 1'b1) begin
            fails++; $display("FAIL reset_async outs=%h idle=%b exp 0/1", outs, idle);
        end
        fq.delete();
        cycle();
        rst = 1'b1;
        mem_req_ready = 1'b1;
        repeat (3) cycle();
        tests++;
        if (mem_req_valid !== 1'b0 || log_src.size() != 0 || idle !== 1'b1) begin
            fails++; $display("FAIL reset_flushed valid=%b issued=%0d idle=%b exp 0/0/1", mem_req_valid, log_src.size(), idle);
        end
    endtask

    task automatic test_single_source();
        reset_dut();
        mem_req_ready = 1'b1;
        drive_b(42'h10, 42'h20, 6'd5, 1'b1);
        cycle();
        b_req_valid = 1'b0;
        tests++;
        if (mem_req_valid !== 1'b1 || mem_req_src !== 1'b1 || mem_addr_k !== 42'h10 ||
            mem_addr_l !== 42'h20 || mem_read_num !== 6'd5) begin
            fails++; $display("FAIL single_issue valid=%b src=%b k=%h l=%h rn=%0d exp 1/1/10/20/5",
                              mem_req_valid, mem_req_src, mem_addr_k, mem_addr_l, mem_read_num);
        end
        cycle();
        tests++;
        if (outstanding !== 6'd1 || mem_req_valid !== 1'b0) begin
            fails++; $display("FAIL single_outst outst=%0d valid=%b exp 1/0", outstanding, mem_req_valid);
        end
        mem_rsp_valid = 1'b1;
        cycle();
        mem_rsp_valid = 1'b0;
        tests++;
        if (outstanding !== 6'd0 || err_underflow !== 1'b0 || idle !== 1'b1) begin
            fails++; $display("FAIL single_rsp outst=%0d unf=%b idle=%b exp 0/0/1", outstanding, err_underflow, idle);
        end
    endtask

    task automatic test_round_robin();
        logic [RN_W-1:0] exp_rn[4] = '{6'd1, 6'd2, 6'd3, 6'd4};
        logic            exp_src[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        reset_dut();
        mem_req_ready = 1'b1;
        drive_f(42'hF0, 42'hF00, 6'd1, 1'b1);
        drive_b(42'hB0, 42'hB00, 6'd2, 1'b1);
        cycle();
        drive_f(42'hF1, 42'hF01, 6'd3, 1'b1);
        drive_b(42'hB1, 42'hB01, 6'd4, 1'b1);
        cycle();
        f_req_valid = 1'b0; b_req_valid = 1'b0;
        repeat (5) cycle();
        tests++;
        if (log_rn.size() != 4) begin
            fails++; $display("FAIL rr_count issued=%0d exp 4", log_rn.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                tests++;
                if (log_rn[i] !== exp_rn[i] || log_src[i] !== exp_src[i] || log_cyc[i] != log_cyc[0] + i) begin
                    fails++; $display("FAIL rr_order idx=%0d got rn=%0d src=%b cyc=%0d exp rn=%0d src=%b cyc=%0d",
                                      i, log_rn[i], log_src[i], log_cyc[i], exp_rn[i], exp_src[i], log_cyc[0] + i);
                end
            end
        end
    endtask

    task automatic test_lock_overflow();
        int budget;
        reset_dut();
        drive_b(42'hB0, 42'hB1, 6'd7, 1'b1);
        cycle();
        b_req_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive_f(42'(32'h100 + i), 42'(32'h200 + i), 6'(10 + i), i < 4);
            cycle();
            tests++;
            if (mem_req_valid !== 1'b1 || mem_req_src !== 1'b1 || mem_addr_k !== 42'hB0 ||
                mem_addr_l !== 42'hB1 || mem_read_num !== 6'd7) begin
                fails++; $display("FAIL lock_stable cyc=%0d valid=%b src=%b k=%h rn=%0d exp 1/1/b0/7",
                                  i, mem_req_valid, mem_req_src, mem_addr_k, mem_read_num);
            end
            tests++;
            if (f_stall !== (i >= 2) || err_overflow !== (i == 4)) begin
                fails++; $display("FAIL lock_stall_ovf push=%0d stall=%b ovf=%b exp %b/%b",
                                  i + 1, f_stall, err_overflow, i >= 2, i == 4);
            end
        end
        f_req_valid = 1'b0;
        mem_req_ready = 1'b1;
        budget = 0;
        while ((fq.size() != 0 || bq.size() != 0) && budget < 20) begin
            cycle();
            budget++;
        end
        tests++;
        if (fq.size() != 0 || bq.size() != 0) begin
            fails++; $display("FAIL lock_drain_timeout left f=%0d b=%0d exp 0/0", fq.size(), bq.size());
        end
        cycle();
        tests++;
        if (log_src.size() != 5 || log_src[0] !== 1'b1 || err_overflow !== 1'b1 || mem_req_valid !== 1'b0) begin
            fails++; $display("FAIL lock_after issued=%0d first_src=%b ovf=%b valid=%b exp 5/1/1/0",
                              log_src.size(), log_src.size() ? log_src[0] : 1'bx, err_overflow, mem_req_valid);
        end
    endtask

    task automatic test_credits();
        reset_dut();
        mem_req_ready = 1'b1;
        for (int i = 0; i < 34; i++) begin
            drive_f(42'(i), 42'(i + 1000), 6'(i), 1'b1);
            cycle();
        end
        f_req_valid = 1'b0;
        repeat (2) cycle();
        tests++;
        if (outstanding !== 6'd32 || mem_req_valid !== 1'b0 || log_src.size() != 32 || fq.size() != 2) begin
            fails++; $display("FAIL credit_exhaust outst=%0d valid=%b issued=%0d exp 32/0/32",
                              outstanding, mem_req_valid, log_src.size());
        end
        mem_rsp_valid = 1'b1;
        cycle();
        mem_rsp_valid = 1'b0;
        tests++;
        if (outstanding !== 6'd31 || mem_req_valid !== 1'b1) begin
            fails++; $display("FAIL credit_return outst=%0d valid=%b exp 31/1", outstanding, mem_req_valid);
        end
        cycle();
        tests++;
        if (outstanding !== 6'd32 || mem_req_valid !== 1'b0 || log_src.size() != 33) begin
            fails++; $display("FAIL credit_one_more outst=%0d valid=%b issued=%0d exp 32/0/33",
                              outstanding, mem_req_valid, log_src.size());
        end
        mem_rsp_valid = 1'b1;
        cycle();
        cycle();
        mem_rsp_valid = 1'b0;
        tests++;
        if (outstanding !== 6'd31 || log_src.size() != 34 || mem_req_valid !== 1'b0 || err_underflow !== 1'b0) begin
            fails++; $display("FAIL credit_simul outst=%0d issued=%0d valid=%b unf=%b exp 31/34/0/0",
                              outstanding, log_src.size(), mem_req_valid, err_underflow);
        end
    endtask

    task automatic test_underflow();
        reset_dut();
        mem_rsp_valid = 1'b1;
        cycle();
        mem_rsp_valid = 1'b0;
        cycle();
        tests++;
        if (err_underflow !== 1'b1 || outstanding !== 6'd0 || err_overflow !== 1'b0 || idle !== 1'b1) begin
            fails++; $display("FAIL underflow unf=%b outst=%0d ovf=%b idle=%b exp 1/0/0/1",
                              err_underflow, outstanding, err_overflow, idle);
        end
    endtask

    initial begin
        test_reset();
        test_single_source();
        test_round_robin();
        test_lock_overflow();
        test_credits();
        test_underflow();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
